// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: default widths, bubble control word,
// occupancy encoding.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CTRL_W_DEF = 23;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned OCC_W      = 2;

  // Control word driven while no valid beat is presented (a legal NOP downstream)
  localparam logic [CTRL_W_DEF-1:0] NOP_CTRL_DEF = '0;

  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module pipe_stall_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count stall cycles, holding at all-ones once reached
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: main + skid entry under valid/ready, registered in_ready,
// flush inserts a bubble, stall-cycle counter for observability.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       CTRL_W   = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(NOP_CTRL_DEF),
  parameter int unsigned       CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  occ_e              occ;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              acc_c;
  logic              pop_c;

  assign acc_c     = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;
  assign occupancy = occ;

  // Occupancy state machine; out_ctrl/out_data are the main entry, bubbled when empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ       <= OCC_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_ctrl  <= NOP_CTRL;
      out_data  <= '0;
      skid_ctrl <= NOP_CTRL;
      skid_data <= '0;
    end else if (flush) begin
      // Offered beat is dropped; a coinciding pop was already taken downstream
      occ       <= OCC_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_ctrl  <= NOP_CTRL;
      out_data  <= '0;
      skid_ctrl <= NOP_CTRL;
      skid_data <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (acc_c) begin
            occ       <= OCC_ONE;
            out_valid <= 1'b1;
            out_ctrl  <= in_ctrl;
            out_data  <= in_data;
          end
        end
        OCC_ONE: begin
          if (acc_c && pop_c) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
          end else if (acc_c) begin
            occ       <= OCC_FULL;
            in_ready  <= 1'b0;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (pop_c) begin
            occ       <= OCC_EMPTY;
            out_valid <= 1'b0;
            out_ctrl  <= NOP_CTRL;
            out_data  <= '0;
          end
        end
        OCC_FULL: begin
          if (pop_c) begin
            occ       <= OCC_ONE;
            in_ready  <= 1'b1;
            out_ctrl  <= skid_ctrl;
            out_data  <= skid_data;
            skid_ctrl <= NOP_CTRL;
            skid_data <= '0;
          end
        end
        default: begin
          occ       <= OCC_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_ctrl  <= NOP_CTRL;
          out_data  <= '0;
        end
      endcase
    end
  end

  pipe_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && !out_ready),
    .clr   (stall_clr),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: table of per-cycle vectors plus hand sequences
// for stall saturation and asynchronous reset.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 23;
  localparam int unsigned NW = 4;
  localparam logic [CW-1:0] NOP = 23'h5A5A5;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;
  logic          stall_clr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .NOP_CTRL (NOP),
    .CNT_W    (NW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic        erdy;
    logic [1:0]  eocc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [CW-1:0] ctl_of(input logic [DW-1:0] d);
    return d[CW-1:0] ^ 23'h12345;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] ed,
                         input logic erdy, input logic [1:0] eocc);
    chk({tag, " out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, " out_data"}, 64'(out_data), 64'(ev ? ed : 32'h0));
    chk({tag, " out_ctrl"}, 64'(out_ctrl), 64'(ev ? ctl_of(ed) : NOP));
    chk({tag, " in_ready"}, 64'(in_ready), 64'(erdy));
    chk({tag, " occupancy"}, 64'(occupancy), 64'(eocc));
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic fl, input logic clr);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = ctl_of(d);
    out_ready = ordy;
    flush     = fl;
    stall_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Stream 1..8 at full rate, then drain
    for (int i = 1; i <= 8; i++) tbl.push_back('{1'b1, 32'(i), 1'b1, 1'b0, 1'b1, 32'(i), 1'b1, 2'd1});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0});
    // Back-pressure A,B,C then release in order
    tbl.push_back('{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 2'd1});
    tbl.push_back('{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2});
    tbl.push_back('{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2});
    tbl.push_back('{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2});
    tbl.push_back('{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hB, 1'b1, 2'd1});
    tbl.push_back('{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hC, 1'b1, 2'd1});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0});
    // Fill to FULL, flush with beat 9 offered: 9 must be dropped
    tbl.push_back('{1'b1, 32'h21, 1'b0, 1'b0, 1'b1, 32'h21, 1'b1, 2'd1});
    tbl.push_back('{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h21, 1'b0, 2'd2});
    tbl.push_back('{1'b1, 32'h9, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 2'd0});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0});
    // Pop coinciding with flush, and flush while empty with a beat offered
    tbl.push_back('{1'b1, 32'h31, 1'b0, 1'b0, 1'b1, 32'h31, 1'b1, 2'd1});
    tbl.push_back('{1'b1, 32'h32, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 2'd0});
    tbl.push_back('{1'b1, 32'h33, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 2'd0});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0});

    // Reset held with a beat offered
    reset = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk_out("reset", 1'b0, 32'h0, 1'b1, 2'd0);
    chk("reset stall_cnt", 64'(stall_cnt), 64'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    tick();
    chk_out("post-reset idle", 1'b0, 32'h0, 1'b1, 2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, 1'b0);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].erdy, tbl[i].eocc);
    end

    // Stall counter: clear, then hold one beat stalled for 20 cycles
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("stall clr idle", 64'(stall_cnt), 64'h0);
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stall first accept", 64'(stall_cnt), 64'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("stall k=%0d", k), 64'(stall_cnt), 64'(k > 15 ? 15 : k));
    end
    chk_out("stall held beat", 1'b1, 32'h77, 1'b1, 2'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("stall clr wins", 64'(stall_cnt), 64'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stall after clr", 64'(stall_cnt), 64'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("stall kept by flush", 64'(stall_cnt), 64'h2);
    chk_out("flush stalled", 1'b0, 32'h0, 1'b1, 2'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stall idle hold", 64'(stall_cnt), 64'h2);

    // Asynchronous reset between edges while holding a beat
    drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("pre async reset", 1'b1, 32'h44, 1'b1, 2'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_out("async reset", 1'b0, 32'h0, 1'b1, 2'd0);
    chk("async reset stall_cnt", 64'(stall_cnt), 64'h0);
    #2;
    reset = 1'b1;
    drive(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("first beat after reset", 1'b1, 32'h55, 1'b1, 2'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("drain after reset", 1'b0, 32'h0, 1'b1, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
